// File: rtl/pipe_evt_pkg.sv
// Shared FSM encoding and default sizing for the pipeline event counter.
package pipe_evt_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  localparam int NUM_CH_DEF   = 4;
  localparam int CNT_W_DEF    = 32;
  localparam int SATURATE_DEF = 0;
endpackage

// File: rtl/pipe_event_counter_cell.sv
// One counter lane: wrap or saturate on overflow, sticky ovf, clear beats increment.
module event_counter_cell #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (en_i) begin
      if (&cnt_q) begin
        ovf_d = 1'b1;
        if (SATURATE == 0) cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;
endmodule

// File: rtl/pipe_event_counter.sv
// Performance counter block: cycle counter plus NUM_CH event lanes, snapshot bank, registered read port.
module pipe_event_counter
  import pipe_evt_pkg::*;
#(
  parameter int NUM_CH   = NUM_CH_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int SATURATE = SATURATE_DEF,
  localparam int SEL_W   = $clog2(NUM_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              freeze_i,
  input  logic              clear_i,
  input  logic              snap_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  input  logic              rd_snap_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [NUM_CH:0]   ovf_o,
  output logic [1:0]        state_o
);
  state_t                      state_q;
  logic                        run;
  logic [NUM_CH:0]             cnt_en;
  logic [NUM_CH:0][CNT_W-1:0]  live;
  logic [NUM_CH:0][CNT_W-1:0]  snap_q, snap_d;
  logic [CNT_W-1:0]            rd_data_q, rd_data_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start_i) state_q <= ST_RUN;
        ST_RUN:    if (!start_i) state_q <= ST_IDLE;
                   else if (freeze_i) state_q <= ST_FROZEN;
        ST_FROZEN: if (!start_i) state_q <= ST_IDLE;
                   else if (!freeze_i) state_q <= ST_RUN;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Lane 0 is the free-running cycle counter; lane k+1 follows event_i[k].
  assign run    = (state_q == ST_RUN);
  assign cnt_en = {event_i & {NUM_CH{run}}, run};

  for (genvar k = 0; k <= NUM_CH; k++) begin : g_cell
    event_counter_cell #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cell (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .en_i  (cnt_en[k]),
      .cnt_o (live[k]),
      .ovf_o (ovf_o[k])
    );
  end

  always_comb begin
    snap_d = snap_q;
    if (snap_i) snap_d = live;
    rd_data_d = '0;
    for (int k = 0; k <= NUM_CH; k++)
      if (rd_sel_i == SEL_W'(k)) rd_data_d = rd_snap_i ? snap_q[k] : live[k];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_q    <= '0;
      rd_data_q <= '0;
    end else begin
      snap_q    <= snap_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_pipe_event_counter.sv
// Directed bench: default-sized counter plus two 8-bit instances (wrap and saturate) on shared stimulus.
module tb_pipe_event_counter;
  logic        clk = 1'b0;
  logic        rst, start, freeze, clear, snap, rd_snap;
  logic [3:0]  evt;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data;
  logic [4:0]  ovf;
  logic [1:0]  state;
  logic [7:0]  rd_w8, rd_s8;
  logic [4:0]  ovf_w8, ovf_s8;
  logic [1:0]  st_w8, st_s8;
  int          tests_run = 0;
  int          failed    = 0;

  always #5 clk = ~clk;

  pipe_event_counter u_dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clear_i(clear),
    .snap_i(snap), .event_i(evt), .rd_sel_i(rd_sel), .rd_snap_i(rd_snap),
    .rd_data_o(rd_data), .ovf_o(ovf), .state_o(state));

  pipe_event_counter #(.CNT_W(8), .SATURATE(0)) u_wrap8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clear_i(clear),
    .snap_i(snap), .event_i(evt), .rd_sel_i(rd_sel), .rd_snap_i(rd_snap),
    .rd_data_o(rd_w8), .ovf_o(ovf_w8), .state_o(st_w8));

  pipe_event_counter #(.CNT_W(8), .SATURATE(1)) u_sat8 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .freeze_i(freeze), .clear_i(clear),
    .snap_i(snap), .event_i(evt), .rd_sel_i(rd_sel), .rd_snap_i(rd_snap),
    .rd_data_o(rd_s8), .ovf_o(ovf_s8), .state_o(st_s8));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; freeze = 1'b0; clear = 1'b0; snap = 1'b0;
    evt = '0; rd_sel = '0; rd_snap = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel, input logic snp);
    rd_sel = sel; rd_snap = snp;
    tick();
  endtask

  task automatic test_reset;
    do_reset();
    tests_run++;
    if (state !== 2'd0) begin failed++; $display("FAIL reset_state got %0d want 0", state); end
    tests_run++;
    if (ovf !== 5'd0) begin failed++; $display("FAIL reset_ovf got %b want 00000", ovf); end
    tests_run++;
    if (rd_data !== 32'd0) begin failed++; $display("FAIL reset_rd got %0d want 0", rd_data); end
  endtask

  task automatic test_basic_count;
    int exp_ch [0:4];
    exp_ch = '{10, 3, 0, 0, 0};
    do_reset();
    start = 1'b1;
    tick();
    tests_run++;
    if (state !== 2'd1) begin failed++; $display("FAIL basic_run_state got %0d want 1", state); end
    for (int i = 0; i < 10; i++) begin
      evt   = (i == 1 || i == 4 || i == 7) ? 4'b0001 : 4'b0000;
      start = (i != 9);
      tick();
    end
    evt = '0;
    tests_run++;
    if (state !== 2'd0) begin failed++; $display("FAIL basic_idle_state got %0d want 0", state); end
    for (int s = 0; s <= 4; s++) begin
      rd(3'(s), 1'b0);
      tests_run++;
      if (rd_data !== 32'(exp_ch[s])) begin
        failed++; $display("FAIL basic_sel%0d got %0d want %0d", s, rd_data, exp_ch[s]);
      end
    end
  endtask

  task automatic test_freeze;
    do_reset();
    start = 1'b1;
    tick();
    tests_run++;
    if (state !== 2'd1) begin failed++; $display("FAIL frz_state_run1 got %0d want 1", state); end
    repeat (4) tick();
    freeze = 1'b1;
    tick();
    tests_run++;
    if (state !== 2'd2) begin failed++; $display("FAIL frz_state_frozen got %0d want 2", state); end
    repeat (3) tick();
    freeze = 1'b0;
    tick();
    tests_run++;
    if (state !== 2'd1) begin failed++; $display("FAIL frz_state_run2 got %0d want 1", state); end
    tick();
    start = 1'b0;
    tick();
    rd(3'd0, 1'b0);
    tests_run++;
    if (rd_data !== 32'd7) begin failed++; $display("FAIL frz_cycles got %0d want 7", rd_data); end
  endtask

  task automatic test_overflow;
    do_reset();
    start = 1'b1;
    tick();
    for (int i = 0; i < 257; i++) begin
      start = (i != 256);
      tick();
    end
    rd(3'd0, 1'b0);
    tests_run++;
    if (rd_w8 !== 8'd1) begin failed++; $display("FAIL wrap_cnt got %0d want 1", rd_w8); end
    tests_run++;
    if (ovf_w8 !== 5'b00001) begin failed++; $display("FAIL wrap_ovf got %b want 00001", ovf_w8); end
    tests_run++;
    if (rd_s8 !== 8'd255) begin failed++; $display("FAIL sat_cnt got %0d want 255", rd_s8); end
    tests_run++;
    if (ovf_s8 !== 5'b00001) begin failed++; $display("FAIL sat_ovf got %b want 00001", ovf_s8); end
    tests_run++;
    if (rd_data !== 32'd257) begin failed++; $display("FAIL wide_cnt got %0d want 257", rd_data); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests_run++;
    if (ovf_w8 !== 5'd0 || ovf_s8 !== 5'd0) begin
      failed++; $display("FAIL ovf_clear got %b/%b want 00000", ovf_w8, ovf_s8);
    end
  endtask

  task automatic test_snap_clear;
    do_reset();
    start = 1'b1;
    tick();
    evt = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      start = (i != 19);
      tick();
    end
    evt = '0;
    snap = 1'b1; clear = 1'b1;
    tick();
    snap = 1'b0; clear = 1'b0;
    rd(3'd0, 1'b1);
    tests_run++;
    if (rd_data !== 32'd20) begin failed++; $display("FAIL snclr_snap0 got %0d want 20", rd_data); end
    rd(3'd3, 1'b1);
    tests_run++;
    if (rd_data !== 32'd20) begin failed++; $display("FAIL snclr_snap3 got %0d want 20", rd_data); end
    rd(3'd0, 1'b0);
    tests_run++;
    if (rd_data !== 32'd0) begin failed++; $display("FAIL snclr_live0 got %0d want 0", rd_data); end
    rd(3'd3, 1'b0);
    tests_run++;
    if (rd_data !== 32'd0) begin failed++; $display("FAIL snclr_live3 got %0d want 0", rd_data); end
    tests_run++;
    if (ovf !== 5'd0) begin failed++; $display("FAIL snclr_ovf got %b want 00000", ovf); end
  endtask

  task automatic test_snap_run;
    do_reset();
    start = 1'b1;
    tick();
    repeat (6) tick();
    snap = 1'b1;
    tick();
    snap = 1'b0; start = 1'b0;
    tick();
    rd(3'd0, 1'b1);
    tests_run++;
    if (rd_data !== 32'd6) begin failed++; $display("FAIL snrun_snap got %0d want 6", rd_data); end
    rd(3'd0, 1'b0);
    tests_run++;
    if (rd_data !== 32'd8) begin failed++; $display("FAIL snrun_live got %0d want 8", rd_data); end
  endtask

  task automatic test_clear_in_run;
    do_reset();
    start = 1'b1;
    tick();
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    start = 1'b0;
    tick();
    rd(3'd0, 1'b0);
    tests_run++;
    if (rd_data !== 32'd2) begin failed++; $display("FAIL clrrun_cnt got %0d want 2", rd_data); end
  endtask

  task automatic test_reset_mid_run;
    do_reset();
    start = 1'b1;
    tick();
    evt = 4'hF;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    repeat (4) tick();
    rst = 1'b1; clear = 1'b1; snap = 1'b1;
    tick();
    tests_run++;
    if (state !== 2'd0) begin failed++; $display("FAIL rstrun_state got %0d want 0", state); end
    tests_run++;
    if (ovf !== 5'd0) begin failed++; $display("FAIL rstrun_ovf got %b want 00000", ovf); end
    tests_run++;
    if (rd_data !== 32'd0) begin failed++; $display("FAIL rstrun_rd got %0d want 0", rd_data); end
    rst = 1'b0; clear = 1'b0; snap = 1'b0; start = 1'b0; evt = '0;
    for (int s = 0; s <= 4; s++) begin
      rd(3'(s), 1'b0);
      tests_run++;
      if (rd_data !== 32'd0) begin failed++; $display("FAIL rstrun_live%0d got %0d want 0", s, rd_data); end
      rd(3'(s), 1'b1);
      tests_run++;
      if (rd_data !== 32'd0) begin failed++; $display("FAIL rstrun_snap%0d got %0d want 0", s, rd_data); end
    end
  endtask

  task automatic test_oob_and_drop;
    do_reset();
    start = 1'b1;
    tick();
    evt = 4'hF;
    repeat (3) tick();
    freeze = 1'b1;
    tick();
    evt = '0;
    rd(3'd4, 1'b0);
    tests_run++;
    if (rd_data !== 32'd4) begin failed++; $display("FAIL oob_ch3 got %0d want 4", rd_data); end
    rd(3'd5, 1'b0);
    tests_run++;
    if (rd_data !== 32'd0) begin failed++; $display("FAIL oob_sel5 got %0d want 0", rd_data); end
    tests_run++;
    if (state !== 2'd2) begin failed++; $display("FAIL oob_frozen got %0d want 2", state); end
    start = 1'b0;
    tick();
    tests_run++;
    if (state !== 2'd0) begin failed++; $display("FAIL drop_idle got %0d want 0", state); end
  endtask

  initial begin
    test_reset();
    test_basic_count();
    test_freeze();
    test_overflow();
    test_snap_clear();
    test_snap_run();
    test_clear_in_run();
    test_reset_mid_run();
    test_oob_and_drop();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule

// File: doc/pipe_event_counter.md
PIPE_EVENT_COUNTER -- requirements
Module: pipe_event_counter

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of event channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32, width of each counter (8..64).
REQ-003 SHALL have parameter SATURATE, default 0; 0 = counters wrap, 1 = counters saturate.
REQ-004 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start_i  input  1  level; counting allowed while 1 (CPU start).
REQ-007 SHALL have port freeze_i  input  1  level; pause counting without losing values.
REQ-008 SHALL have port clear_i  input  1  pulse; zero all live counters and overflow flags.
REQ-009 SHALL have port snap_i  input  1  pulse; copy live counters to snapshot bank.
REQ-010 SHALL have port event_i  input  NUM_CH  per-channel event strobe (e.g. stall, flush); one count per cycle high.
REQ-011 SHALL have port rd_sel_i  input  $clog2(NUM_CH+1)  read select; 0 = cycle counter, k = channel k-1.
REQ-012 SHALL have port rd_snap_i  input  1  0 = read live bank, 1 = read snapshot bank.
REQ-013 SHALL have port rd_data_o  output  CNT_W  registered read data.
REQ-014 SHALL have port ovf_o  output  NUM_CH+1  sticky overflow flags; bit 0 = cycle counter.
REQ-015 SHALL have port state_o  output  2  current FSM state.

Function
REQ-016 SHALL implement FSM IDLE(0), RUN(1), FROZEN(2); encoding 3 unused, recovers to IDLE next cycle.
REQ-017 SHALL transition IDLE->RUN when start_i=1; RUN->FROZEN when freeze_i=1; FROZEN->RUN when freeze_i=0; RUN/FROZEN->IDLE when start_i=0 (start_i=0 dominates freeze_i).
REQ-018 SHALL increment counters only in cycles where state_o==RUN at the rising edge; the transition cycle into RUN does not count.
REQ-019 SHALL increment the cycle counter by 1 every RUN cycle, and channel k by 1 in each RUN cycle where event_i[k]=1; channels independent, simultaneous events all count.
REQ-020 SHALL, with SATURATE=0, wrap all-ones to 0 and set the channel's ovf bit on that increment.
REQ-021 SHALL, with SATURATE=1, hold at all-ones and set the ovf bit on the first attempted increment past all-ones.
REQ-022 SHALL keep ovf bits sticky until clear_i or rst_i.
REQ-023 SHALL on clear_i zero all live counters and ovf_o next cycle; clear dominates any same-cycle increment; snapshot bank unaffected.
REQ-024 SHALL on snap_i capture live counter values as registered before that edge (excluding the same-cycle increment).
REQ-025 SHALL, when snap_i and clear_i coincide, capture pre-clear values then clear live bank.
REQ-026 SHALL present rd_data_o one cycle after rd_sel_i/rd_snap_i are sampled; rd_sel_i > NUM_CH returns 0.
REQ-027 SHALL accept clear_i, snap_i and reads in any FSM state.

Reset
REQ-028 SHALL on rst_i=1 set state IDLE, all live and snapshot counters 0, ovf_o 0, rd_data_o 0, at the next edge.
REQ-029 SHALL give rst_i priority over all other inputs, including mid-RUN events and clear/snap pulses.

Structure
REQ-030 SHALL place FSM state encoding and default parameter constants in shared package pipe_evt_pkg.
REQ-031 SHALL use one sub-module event_counter_cell (one CNT_W counter with wrap/saturate, ovf, clear, enable), instantiated NUM_CH+1 times.
REQ-032 SHALL contain no combinational path from any input to rd_data_o.

Verification
REQ-033 SHALL test: reset, start_i=1, 10 RUN cycles with event_i[0]=1 on 3 of them -> read sel 0 = 10, sel 1 = 3, others 0.
REQ-034 SHALL test: RUN 5 cycles, freeze_i=1 for 4 cycles, RUN 2 more -> cycle counter = 7, state_o 1->2->1.
REQ-035 SHALL test: CNT_W=8, SATURATE=0, 257 RUN cycles -> cycle counter = 1, ovf_o[0]=1; SATURATE=1 -> 255, ovf_o[0]=1.
REQ-036 SHALL test: counters at 20, snap_i and clear_i same cycle -> snapshot read 20, live read 0, ovf_o 0.
REQ-037 SHALL test: rst_i asserted mid-RUN with events active -> next cycle state_o=0, all reads 0, ovf_o=0.
REQ-038 SHALL test: rd_sel_i = NUM_CH+1 -> rd_data_o = 0 one cycle later; start_i dropped while frozen -> IDLE.
